md_unit: RTL

Multiply/divide sequencer owning the HI/LO register pair of the five-stage pipeline. It accepts mult/multu/div/divu/mthi/mtlo commands from the Execute stage and runs multi-cycle operations under a down-counter. It publishes HI/LO to the Execute-stage result mux for mfhi/mflo. It also produces the stall request that holds the Decode stage while any HI/LO-dependent instruction would collide with an operation in flight.

---
 rtl/md_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/md_unit.sv
// md_unit: HI/LO owner that sequences multi-cycle multiply/divide and raises the Decode stall request
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MD_Start,
    input  logic [2:0]  MD_Op,
    input  logic [31:0] MD_A,
    input  logic [31:0] MD_B,
    input  logic        D_UseMD,
    output logic [31:0] MD_HI,
    output logic [31:0] MD_LO,
    output logic        MD_Busy,
    output logic        MD_Stall
);
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);

    md_op_e        op;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d, p_hi_q, p_hi_d, p_lo_q, p_lo_d;
    logic          sgn, idle, is_long;
    logic [63:0]   ext_a, ext_b, prod;
    logic [31:0]   abs_a, abs_b, uq, ur, quo, rem;

    assign op = md_op_e'(MD_Op);

    // Result datapath: sign-extended 64-bit product and magnitude divide with sign fix-up,
    // which also yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case
    always_comb begin
        sgn   = (op == OP_MULT) || (op == OP_DIV);
        ext_a = {{32{sgn & MD_A[31]}}, MD_A};
        ext_b = {{32{sgn & MD_B[31]}}, MD_B};
        prod  = ext_a * ext_b;
        abs_a = (sgn & MD_A[31]) ? -MD_A : MD_A;
        abs_b = (sgn & MD_B[31]) ? -MD_B : MD_B;
        uq    = (abs_b == 32'd0) ? 32'd0 : abs_a / abs_b;
        ur    = (abs_b == 32'd0) ? 32'd0 : abs_a % abs_b;
        quo   = (sgn & (MD_A[31] ^ MD_B[31])) ? -uq : uq;
        rem   = (sgn & MD_A[31]) ? -ur : ur;
    end

    // Sequencer: issue when idle, count down while running, commit pending results on the last edge
    always_comb begin
        idle    = (count_q == '0);
        is_long = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        if (!idle) begin
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
                hi_d = p_hi_q;
                lo_d = p_lo_q;
            end
        end else if (MD_Start) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    {p_hi_d, p_lo_d} = prod;
                    count_d          = CW'(MULT_CYCLES);
                end
                OP_DIV, OP_DIVU: begin
                    // a zero divisor still runs full length but commits the current HI/LO back
                    p_lo_d  = (MD_B == 32'd0) ? lo_q : quo;
                    p_hi_d  = (MD_B == 32'd0) ? hi_q : rem;
                    count_d = CW'(DIV_CYCLES);
                end
                OP_MTHI: hi_d = MD_A;
                OP_MTLO: lo_d = MD_A;
                default: ;
            endcase
        end
        MD_Busy  = (MD_Start & is_long) | !idle;
        MD_Stall = D_UseMD & MD_Busy;
    end

    // State registers with synchronous reset that also aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            p_hi_q  <= 32'd0;
            p_lo_q  <= 32'd0;
        end else begin
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
        end
    end

    assign MD_HI = hi_q;
    assign MD_LO = lo_q;
endmodule
